// File: rtl/face_instr_queue.sv
// Instruction FIFO in front of the FACE top: issues words in order and
// serialises systolic calcs against the engine busy flag.
module face_instr_queue #(
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [31:0]              in_instr,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     busy_i,
   output logic [31:0]              instr_o,
   output logic                     calc_done,
   output logic [CNT_W-1:0]         done_count,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [6:0]    SYSOPCODE = 7'b0001011;
   localparam logic [2:0]    CALC_FUNC = 3'b001;
   localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [31:0]       instr_q, instr_d;
   logic              calc_done_q, calc_done_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
   logic              terr_q, terr_d;
   logic [TW-1:0]     tmo_q, tmo_d;

   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic [31:0]       head;
   logic              head_calc;

   assign empty     = (level_q == '0);
   assign full      = (level_q == LW'(DEPTH));
   assign head      = mem_q[rd_ptr_q];
   assign head_calc = (head[6:0] == SYSOPCODE) && (head[9:7] == CALC_FUNC);
   assign push      = in_valid && !full && !flush;

   // Issue sequencing; a flush suppresses the pop of the current head.
   always_comb begin
      state_d     = state_q;
      instr_d     = 32'h0;
      calc_done_d = 1'b0;
      done_cnt_d  = done_cnt_q;
      terr_d      = terr_q;
      tmo_d       = tmo_q;
      pop         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!flush && !empty) begin
               if (!head_calc) begin
                  instr_d = head;
                  pop     = 1'b1;
               end else if (!busy_i) begin
                  instr_d = head;
                  pop     = 1'b1;
                  tmo_d   = '0;
                  state_d = S_WAIT_BUSY;
               end
            end
         end
         S_WAIT_BUSY: begin
            if (busy_i) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
               terr_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!busy_i) begin
               calc_done_d = 1'b1;
               done_cnt_d  = done_cnt_q + 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_instr;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         instr_q     <= 32'h0;
         calc_done_q <= 1'b0;
         done_cnt_q  <= '0;
         terr_q      <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         instr_q     <= instr_d;
         calc_done_q <= calc_done_d;
         done_cnt_q  <= done_cnt_d;
         terr_q      <= terr_d;
         tmo_q       <= tmo_d;
      end
   end

   assign in_ready    = !full;
   assign instr_o     = instr_q;
   assign calc_done   = calc_done_q;
   assign done_count  = done_cnt_q;
   assign timeout_err = terr_q;
   assign level       = level_q;

endmodule
